// File: rtl/clock_ratio_gen_if.sv
// clock_ratio_gen_if: configuration request/ready handshake selecting a channel and its new divisor.
interface clock_ratio_gen_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 8
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_channel;
  logic [DIV_WIDTH-1:0] cfg_divisor;
  modport master (output cfg_valid, cfg_channel, cfg_divisor, input cfg_ready);
  modport slave  (input cfg_valid, cfg_channel, cfg_divisor, output cfg_ready);
endinterface

// File: rtl/clock_ratio_gen.sv
// clock_ratio_gen: NUM_CH programmable clock-enable/square-wave dividers with glitch-free ratio updates.
// Define CLOCK_RATIO_GEN_LOCK_EN to report lock after LOCK_CYCLES pulses at a stable ratio.
module clock_ratio_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 1,
  parameter int LOCK_CYCLES = 4
) (
  input  logic              base_clock,
  input  logic              reset_n,
  clock_ratio_gen_if.slave  cfg,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] locked
);
  logic [NUM_CH-1:0][DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d, pdiv_q, pdiv_d;
  logic [NUM_CH-1:0] pend_q, pend_d, ce_q, ce_d, clk_q, clk_d, lck_q, lck_d, tc, app, acc;
  logic in_rng;
`ifdef CLOCK_RATIO_GEN_LOCK_EN
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  logic [NUM_CH-1:0][LW-1:0] lk_q, lk_d;
`endif
  assign in_rng        = int'(cfg.cfg_channel) < NUM_CH;
  assign cfg.cfg_ready = in_rng ? ~pend_q[cfg.cfg_channel] : 1'b1;
  assign ce_out        = ce_q;
  assign clk_out       = clk_q;
  assign busy          = pend_q;
  assign locked        = lck_q;
  // A pending divisor is applied only when disabled or at terminal count, so no period is ever cut short
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tc[i]     = div_q[i] != '0 && cnt_q[i] == div_q[i] - DIV_WIDTH'(1);
      app[i]    = pend_q[i] && (div_q[i] == '0 || tc[i]);
      acc[i]    = cfg.cfg_valid && cfg.cfg_ready && in_rng && int'(cfg.cfg_channel) == i;
      div_d[i]  = app[i] ? pdiv_q[i] : div_q[i];
      cnt_d[i]  = (app[i] || tc[i] || div_q[i] == '0) ? '0 : cnt_q[i] + DIV_WIDTH'(1);
      pend_d[i] = acc[i] | (pend_q[i] & ~app[i]);
      pdiv_d[i] = acc[i] ? cfg.cfg_divisor : pdiv_q[i];
      ce_d[i]   = tc[i];
      clk_d[i]  = (div_q[i] == '0 || (app[i] && pdiv_q[i] == '0)) ? 1'b0 : clk_q[i] ^ tc[i];
`ifdef CLOCK_RATIO_GEN_LOCK_EN
      lk_d[i]   = (app[i] || div_q[i] == '0) ? '0 :
                  (tc[i] && lk_q[i] != LW'(LOCK_CYCLES)) ? lk_q[i] + LW'(1) : lk_q[i];
      lck_d[i]  = lk_d[i] == LW'(LOCK_CYCLES);
`else
      lck_d[i]  = div_d[i] != '0;
`endif
    end
  end
  always_ff @(posedge base_clock or negedge reset_n)
    if (!reset_n) begin
      div_q  <= {NUM_CH{DIV_WIDTH'(DEFAULT_DIV)}};
      cnt_q  <= '0;
      pdiv_q <= '0;
      pend_q <= '0;
      ce_q   <= '0;
      clk_q  <= '0;
      lck_q  <= '0;
`ifdef CLOCK_RATIO_GEN_LOCK_EN
      lk_q   <= '0;
`endif
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      ce_q   <= ce_d;
      clk_q  <= clk_d;
      lck_q  <= lck_d;
`ifdef CLOCK_RATIO_GEN_LOCK_EN
      lk_q   <= lk_d;
`endif
    end
endmodule
